// File: rtl/cruise_cmd_panel.sv
// rtl/cruise_cmd_panel.sv - cruise control button/pedal panel: sync, debounce, arbitrate, gate.
// Optional auto-repeat hold FSM enabled by macro CRUISE_CMD_AUTOREPEAT_EN.
module cruise_cmd_panel #(
  parameter int         DEB_CYCLES    = 4,
  parameter int         REPEAT_CYCLES = 8,
  parameter logic [7:0] MIN_SET_SPEED = 8'd46
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_set,
  input  logic       btn_accel,
  input  logic       btn_coast,
  input  logic       btn_cancel,
  input  logic       btn_resume,
  input  logic       pedal_brake,
  input  logic       pedal_throttle,
  input  logic       cruisectrl,
  input  logic [7:0] speed,
  output logic       set,
  output logic       accel,
  output logic       coast,
  output logic       cancel,
  output logic       resume,
  output logic       brake,
  output logic       throttle,
  output logic       err_multi
);

  // Bit order: 0 set, 1 accel, 2 coast, 3 cancel, 4 resume, 5 brake, 6 throttle
  localparam int N = 7;

  logic [N-1:0] raw, s1, s2, lvl;
  logic [3:0]   cnt [N];
  logic [4:0]   lvl_d;
  logic [4:0]   rise;
  logic [4:0]   cmd, cmd_all;
  logic         multi;
  logic         brake_lvl, thr_lvl;

  assign raw = {pedal_throttle, pedal_brake, btn_resume, btn_cancel,
                btn_coast, btn_accel, btn_set};
  assign brake_lvl = lvl[5];
  assign thr_lvl   = lvl[6];
  assign rise      = lvl[4:0] & ~lvl_d;
  assign multi     = ($countones(rise) > 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1  <= '0;
      s2  <= '0;
      lvl <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < N; i++) begin
        if (s2[i] != lvl[i]) begin
          if (cnt[i] == 4'(DEB_CYCLES - 1)) begin
            lvl[i] <= ~lvl[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 4'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Only the highest-priority edge is considered; if its gate fails it is simply dropped.
  always_comb begin
    cmd = '0;
    if (!brake_lvl) begin
      if (rise[3]) begin
        if (cruisectrl) cmd[3] = 1'b1;
      end else if (rise[0]) begin
        if (!cruisectrl && thr_lvl && speed >= MIN_SET_SPEED) cmd[0] = 1'b1;
      end else if (rise[4]) begin
        if (!cruisectrl) cmd[4] = 1'b1;
      end else if (rise[1]) begin
        if (cruisectrl && speed != 8'hFF) cmd[1] = 1'b1;
      end else if (rise[2]) begin
        if (cruisectrl && speed != 8'h00) cmd[2] = 1'b1;
      end
    end
  end

`ifdef CRUISE_CMD_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, HOLD_ACC, HOLD_CST} hold_t;

  hold_t       hold_state, hold_next;
  logic [7:0]  rcnt, rcnt_next;
  logic [4:0]  rep;
  logic [4:0]  fall;

  assign fall = ~lvl[4:0] & lvl_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_state <= IDLE;
      rcnt       <= '0;
    end else begin
      hold_state <= hold_next;
      rcnt       <= rcnt_next;
    end
  end

  // rcnt counts cycles since the last issued pulse; a repeat fires when it reaches the period.
  always_comb begin
    hold_next = hold_state;
    rcnt_next = rcnt;
    rep       = '0;
    case (hold_state)
      HOLD_ACC: begin
        if (fall[1] || brake_lvl || !cruisectrl || (rise & ~5'b00010) != 5'b0) begin
          hold_next = IDLE;
        end else if (rcnt == 8'(REPEAT_CYCLES)) begin
          rcnt_next = 8'd1;
          if (speed != 8'hFF) rep[1] = 1'b1;
        end else begin
          rcnt_next = rcnt + 8'd1;
        end
      end
      HOLD_CST: begin
        if (fall[2] || brake_lvl || !cruisectrl || (rise & ~5'b00100) != 5'b0) begin
          hold_next = IDLE;
        end else if (rcnt == 8'(REPEAT_CYCLES)) begin
          rcnt_next = 8'd1;
          if (speed != 8'h00) rep[2] = 1'b1;
        end else begin
          rcnt_next = rcnt + 8'd1;
        end
      end
      default: hold_next = IDLE;
    endcase
    if (cmd[1]) begin
      hold_next = HOLD_ACC;
      rcnt_next = 8'd1;
    end else if (cmd[2]) begin
      hold_next = HOLD_CST;
      rcnt_next = 8'd1;
    end
  end

  assign cmd_all = cmd | rep;
`else
  assign cmd_all = cmd;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_d     <= '0;
      set       <= 1'b0;
      accel     <= 1'b0;
      coast     <= 1'b0;
      cancel    <= 1'b0;
      resume    <= 1'b0;
      brake     <= 1'b0;
      throttle  <= 1'b0;
      err_multi <= 1'b0;
    end else begin
      lvl_d     <= lvl[4:0];
      set       <= cmd_all[0];
      accel     <= cmd_all[1];
      coast     <= cmd_all[2];
      cancel    <= cmd_all[3];
      resume    <= cmd_all[4];
      brake     <= brake_lvl;
      throttle  <= thr_lvl;
      err_multi <= multi;
    end
  end

endmodule

// File: tb/tb_cruise_cmd_panel.sv
// tb/tb_cruise_cmd_panel.sv - directed self-checking bench for cruise_cmd_panel.
module tb_cruise_cmd_panel;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] btns = '0;
  logic       pedal_brake = 1'b0;
  logic       pedal_throttle = 1'b0;
  logic       cruisectrl = 1'b0;
  logic [7:0] speed = 8'd0;
  logic       set, accel, coast, cancel, resume, brake, throttle, err_multi;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [63:0] m [5];
  logic [63:0] m_err, m_brake;

  always #5 clk = ~clk;

  cruise_cmd_panel dut (
    .clk(clk), .reset(reset),
    .btn_set(btns[0]), .btn_accel(btns[1]), .btn_coast(btns[2]),
    .btn_cancel(btns[3]), .btn_resume(btns[4]),
    .pedal_brake(pedal_brake), .pedal_throttle(pedal_throttle),
    .cruisectrl(cruisectrl), .speed(speed),
    .set(set), .accel(accel), .coast(coast), .cancel(cancel), .resume(resume),
    .brake(brake), .throttle(throttle), .err_multi(err_multi)
  );

  task automatic start();
    cyc = 0;
    for (int i = 0; i < 5; i++) m[i] = '0;
    m_err = '0;
    m_brake = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < 64) begin
      m[0][cyc] = set;
      m[1][cyc] = accel;
      m[2][cyc] = coast;
      m[3][cyc] = cancel;
      m[4][cyc] = resume;
      m_err[cyc] = err_multi;
      m_brake[cyc] = brake;
    end
  endtask

  task automatic settle();
    btns = '0;
    pedal_brake = 1'b0;
    repeat (20) step();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({set, accel, coast, cancel, resume, brake, throttle, err_multi} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000000",
               {set, accel, coast, cancel, resume, brake, throttle, err_multi});
    end
    reset = 1'b0;
    pedal_throttle = 1'b1;
    repeat (12) step();
    checks++;
    if (throttle !== 1'b1) begin
      errors++;
      $display("FAIL throttle_level got %b want 1", throttle);
    end
  endtask

  task automatic test_set_latency();
    cruisectrl = 1'b0;
    speed = 8'd50;
    start();
    btns[0] = 1'b1;
    repeat (10) step();
    btns[0] = 1'b0;
    repeat (15) step();
    checks++;
    if (m[0] !== 64'h80) begin
      errors++;
      $display("FAIL set_latency got %h want %h", m[0], 64'h80);
    end
    checks++;
    if (m_err !== 64'h0) begin
      errors++;
      $display("FAIL set_no_err_multi got %h want 0", m_err);
    end
    settle();
  endtask

  task automatic test_set_speed();
    logic [7:0] spd [2] = '{8'd45, 8'd46};
    logic [63:0] exp [2] = '{64'h0, 64'h80};
    for (int k = 0; k < 2; k++) begin
      cruisectrl = 1'b0;
      speed = spd[k];
      start();
      btns[0] = 1'b1;
      repeat (10) step();
      btns[0] = 1'b0;
      repeat (10) step();
      checks++;
      if (m[0] !== exp[k]) begin
        errors++;
        $display("FAIL set_speed_%0d got %h want %h", spd[k], m[0], exp[k]);
      end
      settle();
    end
  endtask

  task automatic test_glitch();
    cruisectrl = 1'b1;
    speed = 8'd60;
    start();
    btns[1] = 1'b1;
    repeat (3) step();
    btns[1] = 1'b0;
    repeat (12) step();
    checks++;
    if (m[1] !== 64'h0) begin
      errors++;
      $display("FAIL glitch_no_accel got %h want 0", m[1]);
    end
    checks++;
    if (dut.cnt[1] !== 4'd0) begin
      errors++;
      $display("FAIL glitch_counter got %0d want 0", dut.cnt[1]);
    end
    settle();
  endtask

  task automatic test_multi();
    cruisectrl = 1'b1;
    speed = 8'd60;
    start();
    btns[3] = 1'b1;
    btns[1] = 1'b1;
    repeat (10) step();
    btns = '0;
    repeat (10) step();
    checks++;
    if (m[3] !== 64'h80) begin
      errors++;
      $display("FAIL multi_cancel got %h want %h", m[3], 64'h80);
    end
    checks++;
    if (m_err !== 64'h80) begin
      errors++;
      $display("FAIL multi_err got %h want %h", m_err, 64'h80);
    end
    checks++;
    if (m[1] !== 64'h0) begin
      errors++;
      $display("FAIL multi_accel got %h want 0", m[1]);
    end
    settle();
  endtask

  task automatic test_gating();
    int          idx [6] = '{4, 4, 2, 1, 3, 0};
    logic        cc  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0]  sp  [6] = '{8'd60, 8'd60, 8'd0, 8'hFF, 8'd60, 8'd60};
    logic [63:0] exp [6] = '{64'h80, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    for (int k = 0; k < 6; k++) begin
      cruisectrl = cc[k];
      speed = sp[k];
      start();
      btns[idx[k]] = 1'b1;
      repeat (10) step();
      btns = '0;
      repeat (10) step();
      checks++;
      if (m[idx[k]] !== exp[k]) begin
        errors++;
        $display("FAIL gating_%0d got %h want %h", k, m[idx[k]], exp[k]);
      end
      settle();
    end
  endtask

  task automatic test_hold();
    logic [63:0] exp;
`ifdef CRUISE_CMD_AUTOREPEAT_EN
    exp = (64'h1 << 7) | (64'h1 << 15) | (64'h1 << 23) | (64'h1 << 31) | (64'h1 << 39);
`else
    exp = 64'h80;
`endif
    cruisectrl = 1'b1;
    speed = 8'd60;
    start();
    btns[1] = 1'b1;
    repeat (40) step();
    btns[1] = 1'b0;
    repeat (20) step();
    checks++;
    if (m[1] !== exp) begin
      errors++;
      $display("FAIL hold_accel got %h want %h", m[1], exp);
    end
    settle();
  endtask

  task automatic test_brake();
    logic [63:0] exp;
`ifdef CRUISE_CMD_AUTOREPEAT_EN
    exp = (64'h1 << 7) | (64'h1 << 15);
`else
    exp = 64'h80;
`endif
    cruisectrl = 1'b1;
    speed = 8'd60;
    start();
    btns[2] = 1'b1;
    repeat (10) step();
    pedal_brake = 1'b1;
    repeat (30) step();
    checks++;
    if (m[2] !== exp) begin
      errors++;
      $display("FAIL brake_coast got %h want %h", m[2], exp);
    end
    checks++;
    if (m_brake[16] !== 1'b0 || m_brake[17] !== 1'b1) begin
      errors++;
      $display("FAIL brake_latency got c16=%b c17=%b want c16=0 c17=1", m_brake[16], m_brake[17]);
    end
`ifdef CRUISE_CMD_AUTOREPEAT_EN
    checks++;
    if (dut.hold_state !== 2'd0) begin
      errors++;
      $display("FAIL brake_fsm_idle got %0d want 0", dut.hold_state);
    end
`endif
    settle();
  endtask

  task automatic test_reset_mid_hold();
    cruisectrl = 1'b1;
    speed = 8'd60;
    start();
    btns[1] = 1'b1;
    repeat (7) step();
    checks++;
    if (accel !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_accel got %b want 1", accel);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({set, accel, coast, cancel, resume, brake, throttle, err_multi} !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got %b want 00000000",
               {set, accel, coast, cancel, resume, brake, throttle, err_multi});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    start();
    repeat (12) step();
    checks++;
    if (m[1] !== 64'h80) begin
      errors++;
      $display("FAIL reset_new_press got %h want %h", m[1], 64'h80);
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_set_latency();
    test_set_speed();
    test_glitch();
    test_multi();
    test_gating();
    test_hold();
    test_brake();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cruise_cmd_panel.md
CRUISE_CMD_PANEL -- requirements
Module: cruise_cmd_panel

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4, giving the consecutive stable cycles needed to accept a raw input change (range 1..15).
REQ-002 SHALL have parameter REPEAT_CYCLES, default 8, giving the cycle period between auto-repeat pulses (range 2..255).
REQ-003 SHALL have parameter MIN_SET_SPEED, default 8'd46, the lowest speed at which set is accepted.
REQ-004 SHALL have the following ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- btn_set, btn_accel, btn_coast, btn_cancel, btn_resume  in  1 each  raw asynchronous driver buttons.
- pedal_brake, pedal_throttle  in  1 each  raw asynchronous pedal contacts.
- cruisectrl  in  1  engaged flag fed back from the cruise controller.
- speed  in  8  current speed fed back from the cruise controller, unsigned.
- set, accel, coast, cancel, resume  out  1 each  single-cycle command pulses to the controller.
- brake, throttle  out  1 each  debounced level outputs.
- err_multi  out  1  one-cycle pulse when two or more button edges are accepted in the same cycle.

Function
REQ-005 SHALL pass every raw input through a 2-flop synchronizer before any other logic.
REQ-006 SHALL debounce each synchronized input with a per-input counter:
- The counter increments while the synchronized input differs from the debounced level.
- The counter clears on any agreement.
- The debounced level toggles and the counter clears when the count reaches DEB_CYCLES.
REQ-007 SHALL register brake and throttle directly from their debounced levels. A raw change held stable from cycle 0 SHALL appear at the output in cycle DEB_CYCLES+3.
REQ-008 SHALL detect a one-cycle rising edge on each debounced button. A press SHALL yield its pulse in cycle DEB_CYCLES+3, the same latency as REQ-007.
REQ-009 SHALL drive at most one of set/accel/coast/cancel/resume in any cycle.
REQ-010 SHALL arbitrate simultaneous button edges with priority cancel > set > resume > accel > coast, and SHALL pulse err_multi in the same cycle.
REQ-011 SHALL apply these gating rules to the winning edge:
- set: only if cruisectrl==0 and throttle level==1 and speed>=MIN_SET_SPEED.
- cancel, accel, coast: only if cruisectrl==1.
- resume: only if cruisectrl==0.
- accel: suppressed when speed==8'hFF.
- coast: suppressed when speed==8'h00.
REQ-012 SHALL suppress all button pulses while the debounced brake level is 1, including edges that occur in the brake assertion cycle.
REQ-013 SHALL drop suppressed or losing edges. Dropped edges SHALL NOT be queued or replayed.
REQ-014 SHALL run a hold FSM with states IDLE, HOLD_ACC, HOLD_CST and a repeat counter of at least 8 bits:
- IDLE -> HOLD_ACC on an issued accel pulse; IDLE -> HOLD_CST on an issued coast pulse.
- HOLD_x -> IDLE when the debounced button falls, brake is 1, cruisectrl is 0, or a different button edge is accepted.
REQ-015 SHALL issue the first repeat pulse REPEAT_CYCLES cycles after the initial pulse, then every REPEAT_CYCLES cycles while the FSM is in HOLD_x. Repeats SHALL be subject to REQ-011 and REQ-012.
REQ-016 SHALL drive outputs from registers only, with no combinational path from input to output.

Reset
REQ-017 SHALL, on reset assertion and without waiting for a clock, clear all outputs to 0, all synchronizer flops, debounced levels and counters to 0, and the FSM to IDLE.
REQ-018 SHALL, on reset asserted mid-debounce or mid-hold, discard all partial counts. A button held through reset release SHALL register as a new press after DEB_CYCLES+3 cycles.

Configuration
REQ-019 SHALL implement the auto-repeat of REQ-014/REQ-015 only when macro CRUISE_CMD_AUTOREPEAT_EN is defined.
REQ-020 SHALL, without CRUISE_CMD_AUTOREPEAT_EN, omit the hold FSM and repeat counter entirely, and SHALL issue exactly one accel/coast pulse per press regardless of hold time.

Verification
REQ-021 SHALL cover: btn_set held 10 cycles with throttle=1, speed=50, cruisectrl=0, DEB_CYCLES=4 -> one set pulse in cycle 7, then none.
REQ-022 SHALL cover: btn_set pressed at speed=45 -> no pulse; the same press at speed=46 -> one pulse.
REQ-023 SHALL cover: btn_accel glitches 3 cycles high then low with DEB_CYCLES=4 -> no accel pulse, counter back to 0.
REQ-024 SHALL cover: btn_cancel and btn_accel rise together with cruisectrl=1 -> cancel pulse only, err_multi=1 the same cycle, accel=0.
REQ-025 SHALL cover: with CRUISE_CMD_AUTOREPEAT_EN defined, btn_accel held 40 cycles with cruisectrl=1 and speed=60 -> pulses at cycles 7, 15, 23, 31, 39. Without the macro -> a single pulse at cycle 7.
REQ-026 SHALL cover: pedal_brake rising during a coast hold -> brake=1 at cycle DEB_CYCLES+3, no further coast pulses, FSM in IDLE. Reset asserted mid-hold -> all outputs 0 immediately.
